// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the pong datapath blocks (ball engine and
// paddle location processors).
//   state_t    : ball engine FSM states
//   dir_t      : per-axis direction of travel
//   DEF_*      : default screen / paddle / ball geometry
//   ext9       : zero-extend a 9-bit coordinate into the signed 11-bit domain
//   step_coord : advance a coordinate by +/- step in the signed 11-bit domain
// -----------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [1:0] {
        S_SERVE                 = 2'd0,
        S_WAIT_TRANSACTION      = 2'd1,
        S_UPDATE_POSITION       = 2'd2,
        S_WAIT_FRAME_RATE_COUNT = 2'd3
    } state_t;

    typedef enum logic {
        INCREASE = 1'b0,
        DECREASE = 1'b1
    } dir_t;

    localparam logic [8:0]  DEF_BALL_SIZE        = 9'd4;
    localparam logic [8:0]  DEF_PADDLE_WIDTH     = 9'd10;
    localparam logic [8:0]  DEF_PADDLE_HEIGHT    = 9'd48;
    localparam logic [8:0]  DEF_LEFT_PADDLE_X    = 9'd0;
    localparam logic [8:0]  DEF_RIGHT_PADDLE_X   = 9'd310;
    localparam logic [8:0]  DEF_SCREEN_WIDTH     = 9'd320;
    localparam logic [8:0]  DEF_SCREEN_HEIGHT    = 9'd240;
    localparam logic [31:0] DEF_FRAME_RATE_COUNT = 32'd3333332;

    function automatic logic signed [10:0] ext9(input logic [8:0] v);
        return $signed({2'b00, v});
    endfunction

    function automatic logic signed [10:0] step_coord(
        input logic [8:0] pos,
        input dir_t       dir,
        input logic [8:0] step
    );
        return (dir == INCREASE) ? ext9(pos) + ext9(step)
                                 : ext9(pos) - ext9(step);
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// -----------------------------------------------------------------------------
// frame_tick_counter
// Saturating cycle counter used to pace updates to the frame rate.
//   clock    : system clock
//   reset_n  : asynchronous active-low reset
//   i_clear  : synchronous clear (count returns to 0 on the next edge)
//   o_done   : count has reached FRAME_RATE_COUNT (stays high until cleared)
// -----------------------------------------------------------------------------
module frame_tick_counter #(
    parameter logic [31:0] FRAME_RATE_COUNT = 32'd3333332
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    output logic o_done
);

    logic [31:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != FRAME_RATE_COUNT) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_done = (r_count == FRAME_RATE_COUNT);

endmodule

// File: rtl/ball_physics_engine.sv
// -----------------------------------------------------------------------------
// ball_physics_engine
// Moves the ball once per frame tick, reflects it off the top/bottom walls and
// off either paddle, flags a point when a paddle is missed and re-centres the
// ball until the next serve. Offers each position to the drawer via
// m_valid/m_ready.
//   clock, reset_n          : clock, asynchronous active-low reset
//   in_color / out_color    : ball colour, passed straight through
//   left_paddle_y           : top y of left paddle (used during the update)
//   right_paddle_y          : top y of right paddle (used during the update)
//   serve                   : starts play while waiting to serve
//   m_ready / m_valid       : drawer handshake for the current position
//   box_x, box_y            : registered ball top-left corner
//   score_left/score_right  : one-cycle point pulses
// -----------------------------------------------------------------------------
module ball_physics_engine
    import pong_pkg::*;
#(
    parameter logic [8:0]  BALL_SIZE        = DEF_BALL_SIZE,
    parameter logic [8:0]  PADDLE_WIDTH     = DEF_PADDLE_WIDTH,
    parameter logic [8:0]  PADDLE_HEIGHT    = DEF_PADDLE_HEIGHT,
    parameter logic [8:0]  LEFT_PADDLE_X    = DEF_LEFT_PADDLE_X,
    parameter logic [8:0]  RIGHT_PADDLE_X   = DEF_RIGHT_PADDLE_X,
    parameter logic [8:0]  SCREEN_WIDTH     = DEF_SCREEN_WIDTH,
    parameter logic [8:0]  SCREEN_HEIGHT    = DEF_SCREEN_HEIGHT,
    parameter logic [8:0]  STEP_X           = 9'd1,
    parameter logic [8:0]  STEP_Y           = 9'd1,
    parameter logic [31:0] FRAME_RATE_COUNT = DEF_FRAME_RATE_COUNT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] in_color,
    input  logic [8:0] left_paddle_y,
    input  logic [8:0] right_paddle_y,
    input  logic       serve,
    input  logic       m_ready,
    output logic       m_valid,
    output logic [8:0] box_x,
    output logic [8:0] box_y,
    output logic [2:0] out_color,
    output logic       score_left,
    output logic       score_right
);

    localparam logic [8:0] CX      = 9'((SCREEN_WIDTH  - BALL_SIZE) >> 1);
    localparam logic [8:0] CY      = 9'((SCREEN_HEIGHT - BALL_SIZE) >> 1);
    localparam logic [8:0] LE      = 9'(LEFT_PADDLE_X + PADDLE_WIDTH);
    localparam logic [8:0] X_RIGHT = 9'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [8:0] Y_BOT   = 9'(SCREEN_HEIGHT - BALL_SIZE);

    state_t r_state, w_state_next;
    logic [8:0] r_x, r_y, w_x_next, w_y_next, w_y_res;
    dir_t r_vx, r_vy, w_vx_next, w_vy_next, w_vy_res;
    logic r_score_left, r_score_right, w_score_left, w_score_right;
    logic w_frame_done, w_clear;
    logic signed [10:0] w_nx, w_ny;
    logic w_hit_l, w_hit_r;

    frame_tick_counter #(
        .FRAME_RATE_COUNT(FRAME_RATE_COUNT)
    ) u_frame_tick_counter (
        .clock  (clock),
        .reset_n(reset_n),
        .i_clear(w_clear),
        .o_done (w_frame_done)
    );

    // Counter is held at zero until the drawer accepts, so each frame interval
    // starts at the handshake.
    assign w_clear = (r_state == S_SERVE) || (r_state == S_WAIT_TRANSACTION);

    assign w_nx = step_coord(r_x, r_vx, STEP_X);
    assign w_ny = step_coord(r_y, r_vy, STEP_Y);

    assign w_hit_l = (ext9(r_y) + ext9(BALL_SIZE) > ext9(left_paddle_y)) &&
                     (ext9(r_y) < ext9(left_paddle_y) + ext9(PADDLE_HEIGHT));
    assign w_hit_r = (ext9(r_y) + ext9(BALL_SIZE) > ext9(right_paddle_y)) &&
                     (ext9(r_y) < ext9(right_paddle_y) + ext9(PADDLE_HEIGHT));

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SERVE: begin
                if (serve) w_state_next = S_WAIT_TRANSACTION;
            end
            S_WAIT_TRANSACTION: begin
                if (m_ready) w_state_next = S_UPDATE_POSITION;
            end
            S_UPDATE_POSITION: begin
                if (w_score_left || w_score_right) w_state_next = S_SERVE;
                else if (w_frame_done)             w_state_next = S_WAIT_TRANSACTION;
                else                               w_state_next = S_WAIT_FRAME_RATE_COUNT;
            end
            S_WAIT_FRAME_RATE_COUNT: begin
                if (w_frame_done) w_state_next = S_WAIT_TRANSACTION;
            end
            default: w_state_next = S_SERVE;
        endcase
    end

    // Datapath: both axes resolve independently; a score overrides the Y result.
    always_comb begin
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_vx_next     = r_vx;
        w_vy_next     = r_vy;
        w_score_left  = 1'b0;
        w_score_right = 1'b0;
        w_y_res       = w_ny[8:0];
        w_vy_res      = r_vy;

        if (w_ny < 0) begin
            w_y_res  = '0;
            w_vy_res = INCREASE;
        end else if (w_ny + ext9(BALL_SIZE) > ext9(SCREEN_HEIGHT)) begin
            w_y_res  = Y_BOT;
            w_vy_res = DECREASE;
        end

        if (r_state == S_UPDATE_POSITION) begin
            w_x_next  = w_nx[8:0];
            w_y_next  = w_y_res;
            w_vy_next = w_vy_res;

            if ((r_vx == DECREASE) && (w_nx < ext9(LE))) begin
                if (w_hit_l) begin
                    w_x_next  = LE;
                    w_vx_next = INCREASE;
                end else begin
                    w_score_right = 1'b1;
                end
            end else if ((r_vx == INCREASE) &&
                         (w_nx + ext9(BALL_SIZE) > ext9(RIGHT_PADDLE_X))) begin
                if (w_hit_r) begin
                    w_x_next  = X_RIGHT;
                    w_vx_next = DECREASE;
                end else begin
                    w_score_left = 1'b1;
                end
            end

            if (w_score_left || w_score_right) begin
                w_x_next  = CX;
                w_y_next  = CY;
                w_vy_next = r_vy;
                // Serve toward the player who conceded.
                w_vx_next = w_score_right ? DECREASE : INCREASE;
            end
        end
    end

    // Register block
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_SERVE;
            r_x           <= CX;
            r_y           <= CY;
            r_vx          <= INCREASE;
            r_vy          <= INCREASE;
            r_score_left  <= 1'b0;
            r_score_right <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_vx          <= w_vx_next;
            r_vy          <= w_vy_next;
            r_score_left  <= w_score_left;
            r_score_right <= w_score_right;
        end
    end

    // Outputs
    always_comb begin
        m_valid = (r_state == S_WAIT_TRANSACTION);
    end

    assign box_x       = r_x;
    assign box_y       = r_y;
    assign out_color   = in_color;
    assign score_left  = r_score_left;
    assign score_right = r_score_right;

endmodule
